sar_search_ctrl: RTL and testbench

- Successive-approximation search controller that drives the b operand of a magnitude comparator and reads back its lt/eq/gt flags.
- Recovers an unknown target value a in at most WIDTH compare cycles.
- Sits on the initiator side of the existing simple_comparator (a/b → lt/eq/gt) interface.
- Used to recover a hidden/unknown operand; also serves as a self-checking exerciser for the comparator.

---
 rtl/sar_search_ctrl_pkg.sv | 13 +
 rtl/sar_search_ctrl.sv | 115 +++++++++++
 tb/tb_sar_search_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_pkg.sv
// Shared types for the successive-approximation search controller.
// State encodings and the default operand width.
package sar_search_ctrl_pkg;

  localparam int SAR_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRY  = 2'd1,
    ST_DONE = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives comparator b
// with trial values and recovers the unknown operand a bit by bit.
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH,
  localparam int STEPS_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   guess,
  input  logic               cmp_lt,
  input  logic               cmp_eq,
  input  logic               cmp_gt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [STEPS_W-1:0] steps,
  output logic               err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
  localparam logic [STEPS_W-1:0] TOP_IDX = STEPS_W'(WIDTH - 1);

  sar_state_e         state_q, state_d;
  logic [WIDTH-1:0]   guess_q, guess_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [STEPS_W-1:0] bit_idx_q, bit_idx_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   cur_mask;
  logic [WIDTH-1:0]   trial;
  logic               flags_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      guess_q   <= '0;
      result_q  <= '0;
      steps_q   <= '0;
      bit_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      guess_q   <= guess_d;
      result_q  <= result_d;
      steps_q   <= steps_d;
      bit_idx_q <= bit_idx_d;
      err_q     <= err_d;
    end
  end

  assign cur_mask = ONE << bit_idx_q;
  assign flags_ok = $onehot({cmp_lt, cmp_eq, cmp_gt});
  // Current bit resolved by lt, next lower bit tentatively set.
  assign trial = (cmp_lt ? (guess_q & ~cur_mask) : guess_q)
               | (cur_mask >> 1);

  always_comb begin
    state_d   = state_q;
    guess_d   = guess_q;
    result_d  = result_q;
    steps_d   = steps_q;
    bit_idx_d = bit_idx_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          guess_d   = MSB;
          bit_idx_d = TOP_IDX;
          steps_d   = '0;
          err_d     = 1'b0;
          result_d  = '0;
          state_d   = ST_TRY;
        end
      end
      ST_TRY: begin
        steps_d = steps_q + STEPS_W'(1);
        if (!flags_ok) begin
          err_d    = 1'b1;
          result_d = guess_q;
          state_d  = ST_DONE;
        end else if (cmp_eq) begin
          result_d = guess_q;
          state_d  = ST_DONE;
        end else if (bit_idx_q != '0) begin
          guess_d   = trial;
          bit_idx_d = bit_idx_q - STEPS_W'(1);
        end else if (cmp_lt) begin
          result_d = guess_q & ~ONE;
          state_d  = ST_DONE;
        end else begin
          err_d    = 1'b1;
          result_d = guess_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == ST_TRY);
    done   = (state_q == ST_DONE);
    guess  = guess_q;
    result = result_q;
    steps  = steps_q;
    err    = err_q;
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl with a behavioural comparator
// responder and an override path for illegal flag patterns.
module tb_sar_search_ctrl;

  localparam int W = 3;
  localparam int SW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  guess;
  logic          cmp_lt, cmp_eq, cmp_gt;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic [SW-1:0] steps;

  logic [W-1:0]  target;
  logic          force_en;
  logic [2:0]    force_flags;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] gseq [8];
  int gc;

  always #5 clk = ~clk;

  assign {cmp_lt, cmp_eq, cmp_gt} = force_en ? force_flags :
    {target < guess, target == guess, target > guess};

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .guess(guess),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .busy(busy), .done(done), .result(result), .steps(steps),
    .err(err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [W-1:0] tgt,
                     input int rep,
                     input int e_res, input int e_steps,
                     input int e_err);
    int n;
    target = tgt;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    gc = 0;
    while (!done && n < 20) begin
      if (busy && gc < 8) begin
        gseq[gc] = guess;
        gc++;
      end
      if (rep != 0 && n == 1) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    check("no_timeout", 32'(n < 20), 1);
    check("done", 32'(done), 1);
    check("result", 32'(result), e_res);
    check("steps", 32'(steps), e_steps);
    check("err", 32'(err), e_err);
    check("latency", n, e_steps + 1);
    tick();
    check("done_pulse", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("held_result", 32'(result), e_res);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    target = '0;
    force_en = 1'b0;
    force_flags = 3'b000;
    tick();
    tick();
    check("rst_guess", 32'(guess), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_steps", 32'(steps), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b0;
    tick();

    run(3'd5, 0, 5, 3, 0);
    check("seq5_n", gc, 3);
    check("seq5_0", 32'(gseq[0]), 4);
    check("seq5_1", 32'(gseq[1]), 6);
    check("seq5_2", 32'(gseq[2]), 5);

    run(3'd4, 0, 4, 1, 0);

    run(3'd0, 0, 0, 3, 0);
    check("seq0_0", 32'(gseq[0]), 4);
    check("seq0_1", 32'(gseq[1]), 2);
    check("seq0_2", 32'(gseq[2]), 1);

    run(3'd7, 0, 7, 3, 0);
    check("seq7_1", 32'(gseq[1]), 6);
    check("seq7_2", 32'(gseq[2]), 7);
    run(3'd6, 1, 6, 2, 0);
    run(3'd6, 0, 6, 2, 0);

    force_en = 1'b1;
    force_flags = 3'b101;
    run(3'd2, 0, 4, 1, 1);
    force_flags = 3'b000;
    run(3'd2, 0, 4, 1, 1);
    force_en = 1'b0;

    target = 3'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy", 32'(busy), 1);
    check("mid_guess", 32'(guess), 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_guess", 32'(guess), 0);
    check("abort_result", 32'(result), 0);
    check("abort_steps", 32'(steps), 0);
    check("abort_err", 32'(err), 0);
    tick();
    check("abort_no_done", 32'(done), 0);

    run(3'd3, 0, 3, 3, 0);
    check("seq3_1", 32'(gseq[1]), 2);
    check("seq3_2", 32'(gseq[2]), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
